// File: rtl/msg_arbiter.sv
// Round-robin packet arbiter: per-source FIFOs feed one registered message output,
// forwarding whole header+body packets from one source at a time.
module msg_arbiter #(
    parameter int N_IN      = 4,
    parameter int MSG_WIDTH = 32,
    parameter int LEN_WIDTH = 8,
    parameter int FIFO_LOG2 = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_IN*MSG_WIDTH-1:0] in_msg,
    input  logic [N_IN-1:0]           in_msg_nd,
    output logic [MSG_WIDTH-1:0]      out_msg,
    output logic                      out_msg_nd,
    output logic                      error,
    output logic [N_IN-1:0]           error_src
);

    localparam int DEPTH = 1 << FIFO_LOG2;
    localparam int CNT_W = FIFO_LOG2 + 1;
    localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;

    typedef enum logic {IDLE, SEND} state_t;

    function automatic logic is_header(input logic [MSG_WIDTH-1:0] w);
        is_header = w[MSG_WIDTH-1];
    endfunction

    function automatic logic [LEN_WIDTH-1:0] hdr_len(input logic [MSG_WIDTH-1:0] w);
        hdr_len = w[MSG_WIDTH-2 -: LEN_WIDTH];
    endfunction

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] v);
        wrap_inc = (int'(v) == N_IN - 1) ? '0 : v + 1'b1;
    endfunction

    logic [MSG_WIDTH-1:0] mem    [N_IN][DEPTH];
    logic [FIFO_LOG2-1:0] wr_ptr [N_IN];
    logic [FIFO_LOG2-1:0] rd_ptr [N_IN];
    logic [CNT_W-1:0]     cnt    [N_IN];

    logic [N_IN-1:0]      empty, full, pop, wr_en, drop, err_set;
    state_t               state, state_nxt;
    logic [IDX_W-1:0]     rr, rr_nxt, grant, grant_nxt, scan_sel, cur;
    logic                 scan_hit;
    logic [LEN_WIDTH-1:0] rem, rem_nxt;
    logic [MSG_WIDTH-1:0] head_word, out_msg_nxt;
    logic                 out_nd_nxt;
    logic [N_IN-1:0]      error_src_nxt;

    // A full FIFO still accepts a word when its head is popped in the same cycle
    always_comb begin
        for (int i = 0; i < N_IN; i++) begin
            empty[i] = (cnt[i] == '0);
            full[i]  = (cnt[i] == CNT_W'(DEPTH));
            wr_en[i] = in_msg_nd[i] && (!full[i] || pop[i]);
            drop[i]  = in_msg_nd[i] && full[i] && !pop[i];
        end
    end

    always_comb begin
        logic [IDX_W-1:0] idx_v;
        int idx;
        scan_hit = 1'b0;
        scan_sel = '0;
        idx      = 0;
        idx_v    = '0;
        for (int k = 0; k < N_IN; k++) begin
            idx = int'(rr) + k;
            if (idx >= N_IN) idx = idx - N_IN;
            idx_v = IDX_W'(idx);
            if (!scan_hit && !empty[idx_v]) begin
                scan_hit = 1'b1;
                scan_sel = idx_v;
            end
        end
    end

    assign cur       = (state == SEND) ? grant : scan_sel;
    assign head_word = mem[cur][rd_ptr[cur]];

    always_comb begin
        state_nxt   = state;
        rr_nxt      = rr;
        grant_nxt   = grant;
        rem_nxt     = rem;
        pop         = '0;
        err_set     = '0;
        out_nd_nxt  = 1'b0;
        out_msg_nxt = out_msg;
        case (state)
            IDLE: begin
                if (scan_hit) begin
                    pop[scan_sel] = 1'b1;
                    if (is_header(head_word)) begin
                        out_nd_nxt  = 1'b1;
                        out_msg_nxt = head_word;
                        grant_nxt   = scan_sel;
                        rem_nxt     = hdr_len(head_word);
                        if (hdr_len(head_word) != '0) state_nxt = SEND;
                        else                          rr_nxt    = wrap_inc(scan_sel);
                    end else begin
                        // Orphan body word with no header: discard it
                        err_set[scan_sel] = 1'b1;
                    end
                end
            end
            SEND: begin
                if (!empty[grant]) begin
                    if (is_header(head_word)) begin
                        // Packet was shorter than its header claimed; leave the new header queued
                        err_set[grant] = 1'b1;
                        state_nxt      = IDLE;
                        rr_nxt         = wrap_inc(grant);
                    end else begin
                        pop[grant]  = 1'b1;
                        out_nd_nxt  = 1'b1;
                        out_msg_nxt = head_word;
                        rem_nxt     = rem - 1'b1;
                        if (rem == LEN_WIDTH'(1)) begin
                            state_nxt = IDLE;
                            rr_nxt    = wrap_inc(grant);
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign error_src_nxt = error_src | err_set | drop;

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_IN; i++) begin
            if (wr_en[i]) mem[i][wr_ptr[i]] <= in_msg[i*MSG_WIDTH +: MSG_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_IN; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                cnt[i]    <= '0;
            end
            state      <= IDLE;
            rr         <= '0;
            grant      <= '0;
            rem        <= '0;
            out_msg    <= '0;
            out_msg_nd <= 1'b0;
            error_src  <= '0;
            error      <= 1'b0;
        end else begin
            for (int i = 0; i < N_IN; i++) begin
                if (wr_en[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
                if (pop[i])   rd_ptr[i] <= rd_ptr[i] + 1'b1;
                case ({wr_en[i], pop[i]})
                    2'b10:   cnt[i] <= cnt[i] + 1'b1;
                    2'b01:   cnt[i] <= cnt[i] - 1'b1;
                    default: cnt[i] <= cnt[i];
                endcase
            end
            state      <= state_nxt;
            rr         <= rr_nxt;
            grant      <= grant_nxt;
            rem        <= rem_nxt;
            out_msg    <= out_msg_nxt;
            out_msg_nd <= out_nd_nxt;
            error_src  <= error_src_nxt;
            error      <= |error_src_nxt;
        end
    end

endmodule

// File: tb/tb_msg_arbiter.sv
// Bench for msg_arbiter: single-packet vector table plus hand-written contention,
// stall, overflow, orphan-body and reset sequences, checked through an output scoreboard.
module tb_msg_arbiter;

    localparam int N   = 4;
    localparam int MW  = 16;
    localparam int LW  = 4;
    localparam int FL2 = 2;

    logic              clk;
    logic              rst;
    logic [N*MW-1:0]   in_msg;
    logic [N-1:0]      in_msg_nd;
    logic [MW-1:0]     out_msg;
    logic              out_msg_nd;
    logic              error;
    logic [N-1:0]      error_src;

    msg_arbiter #(.N_IN(N), .MSG_WIDTH(MW), .LEN_WIDTH(LW), .FIFO_LOG2(FL2)) dut (
        .clk(clk), .rst(rst), .in_msg(in_msg), .in_msg_nd(in_msg_nd),
        .out_msg(out_msg), .out_msg_nd(out_msg_nd), .error(error), .error_src(error_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [MW-1:0] exp_q [$];

    typedef struct {
        int          src;
        int          len;
        logic [15:0] w0;
        logic [15:0] w1;
        logic [15:0] w2;
        logic [3:0]  exp_err;
    } vec_t;

    vec_t vecs [4];

    // Scoreboard: every valid output word must match the next expected word
    always @(negedge clk) begin
        if (out_msg_nd === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out: got %h, required no output", out_msg);
            end else begin
                logic [MW-1:0] e;
                e = exp_q.pop_front();
                if (out_msg !== e) begin
                    errors++;
                    $display("FAIL out_word: got %h, required %h", out_msg, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic put(input int s, input logic [15:0] w);
        in_msg[s*MW +: MW] = w;
        in_msg_nd[s]       = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        in_msg_nd = '0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d words pending, required 0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    function automatic logic [15:0] vword(input vec_t v, input int j);
        case (j)
            0:       vword = v.w0;
            1:       vword = v.w1;
            default: vword = v.w2;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{src: 0, len: 2, w0: 16'h9000, w1: 16'h0011, w2: 16'h0022, exp_err: 4'b0000};
        vecs[1] = '{src: 2, len: 1, w0: 16'h8800, w1: 16'h0033, w2: 16'h0000, exp_err: 4'b0000};
        vecs[2] = '{src: 1, len: 2, w0: 16'h9000, w1: 16'h0044, w2: 16'h0055, exp_err: 4'b0000};
        vecs[3] = '{src: 3, len: 0, w0: 16'h8000, w1: 16'h0000, w2: 16'h0000, exp_err: 4'b0000};

        rst       = 1'b1;
        in_msg    = '0;
        in_msg_nd = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_out_msg", 32'(out_msg), 32'h0);
        chk("reset_out_nd", 32'(out_msg_nd), 32'h0);
        chk("reset_error", 32'(error), 32'h0);
        chk("reset_error_src", 32'(error_src), 32'h0);

        // Single packets, one source at a time; header must appear one edge after it is written
        for (int v = 0; v < 4; v++) begin
            for (int j = 0; j <= vecs[v].len; j++) exp_q.push_back(vword(vecs[v], j));
            put(vecs[v].src, vecs[v].w0);
            step();
            if (vecs[v].len >= 1) put(vecs[v].src, vecs[v].w1);
            step();
            @(negedge clk);
            chk($sformatf("vec%0d_latency_nd", v), 32'(out_msg_nd), 32'h1);
            chk($sformatf("vec%0d_latency_hdr", v), 32'(out_msg), 32'(vecs[v].w0));
            for (int j = 2; j <= vecs[v].len; j++) begin
                put(vecs[v].src, vword(vecs[v], j));
                step();
            end
            drain();
            chk($sformatf("vec%0d_error_src", v), 32'(error_src), 32'(vecs[v].exp_err));
        end

        // All four sources at once: round-robin order 0..3, eight back-to-back valid cycles
        for (int s = 0; s < N; s++) begin
            exp_q.push_back(16'h8800);
            exp_q.push_back(16'(s * 16));
        end
        for (int s = 0; s < N; s++) put(s, 16'h8800);
        step();
        for (int s = 0; s < N; s++) put(s, 16'(s * 16));
        step();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk($sformatf("t2_contig_%0d", c), 32'(out_msg_nd), 32'h1);
        end
        @(negedge clk);
        chk("t2_idle_after", 32'(out_msg_nd), 32'h0);
        drain();
        chk("t2_error", 32'(error), 32'h0);

        // src1 stalls mid-packet while src2 waits; src2 may only follow src1's last body word
        exp_q.push_back(16'h9000);
        exp_q.push_back(16'h0011);
        exp_q.push_back(16'h0022);
        exp_q.push_back(16'h8800);
        exp_q.push_back(16'h0066);
        put(1, 16'h9000);
        step();
        put(1, 16'h0011);
        put(2, 16'h8800);
        step();
        put(2, 16'h0066);
        step();
        repeat (4) step();
        put(1, 16'h0022);
        step();
        drain();
        chk("t3_error_src", 32'(error_src), 32'h0);

        // src3 holds the grant in stall while src0 overflows its 4-deep FIFO
        exp_q.push_back(16'h9000);
        exp_q.push_back(16'h0011);
        exp_q.push_back(16'h0022);
        exp_q.push_back(16'h9800);
        exp_q.push_back(16'h0001);
        exp_q.push_back(16'h0002);
        exp_q.push_back(16'h0003);
        put(3, 16'h9000);
        step();
        put(3, 16'h0011);
        step();
        for (int j = 0; j < 6; j++) begin
            put(0, (j == 0) ? 16'h9800 : 16'(j));
            step();
            if (j == 3) chk("t4_no_drop_yet", 32'(error_src), 32'h0);
        end
        chk("t4_error_src", 32'(error_src), 32'h1);
        chk("t4_error", 32'(error), 32'h1);
        put(3, 16'h0022);
        step();
        drain();
        chk("t4_error_sticky", 32'(error), 32'h1);

        // Orphan body word on src2: discarded, flagged, nothing forwarded
        put(2, 16'h0055);
        step();
        drain();
        chk("t5_error_src", 32'(error_src), 32'h5);
        chk("t5_error", 32'(error), 32'h1);

        // Reset in the middle of a src0 packet
        exp_q.push_back(16'h9000);
        put(0, 16'h9000);
        step();
        put(0, 16'h0011);
        step();
        @(negedge clk);
        #1;
        exp_q.delete();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("t6_out_nd", 32'(out_msg_nd), 32'h0);
        chk("t6_out_msg", 32'(out_msg), 32'h0);
        chk("t6_error", 32'(error), 32'h0);
        chk("t6_error_src", 32'(error_src), 32'h0);
        repeat (4) @(negedge clk);
        exp_q.push_back(16'h9000);
        exp_q.push_back(16'h00aa);
        exp_q.push_back(16'h00bb);
        put(0, 16'h9000);
        step();
        put(0, 16'h00aa);
        step();
        @(negedge clk);
        chk("t6_latency_nd", 32'(out_msg_nd), 32'h1);
        chk("t6_latency_hdr", 32'(out_msg), 32'h9000);
        put(0, 16'h00bb);
        step();
        drain();
        chk("t6_final_error", 32'(error), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
